nanao_pixmix: RTL and testbench
===============================

NANAO_PIXMIX -- requirements
Module: nanao_pixmix

Interface
REQ-001 Parameter PW, default 8, pixel data width per channel.
REQ-002 Parameter NCH, default 4, number of input channels (2..8).
REQ-003 Parameter TW, default 4, number of low pixel bits used for transparency (1..PW).
REQ-004 Port CLK  input  1  pixel-domain clock; all state SHALL update on its rising edge.
REQ-005 Port nRST  input  1  asynchronous active-low reset.
REQ-006 Port LD  input  1  capture enable; input channels sampled on an edge with LD=1.
REQ-007 Port D  input  NCH*PW  packed channel data, channel i at bits [i*PW +: PW].
REQ-008 Port CEN  input  NCH  per-channel enable, priority mode only.
REQ-009 Port SEL  input  3  channel index, select mode only.
REQ-010 Port MODE  input  1  0 = select mode, 1 = priority mode.
REQ-011 Port P1L  input  1  plane-enable qualifier for E1.
REQ-012 Port FRM  input  1  frame-start pulse (counter clear).
REQ-013 Port CA  output  PW  mixed pixel, registered.
REQ-014 Port VLD  output  1  one-cycle strobe, CA/E1/POL updated.
REQ-015 Port E1  output  1  registered, low when P1L=1 and output pixel opaque.
REQ-016 Port POL  output  1  registered, high when output pixel transparent.
REQ-017 Port TCNT  output  16  transparent-pixel count.

Function
REQ-018 Stage 1: on edge k with LD=1, D, CEN, SEL, MODE, P1L SHALL be registered together; with LD=0 stage 1 holds.
REQ-019 Stage 2: at edge k+1 CA, E1, POL SHALL update from stage 1 and VLD SHALL be 1 for exactly that cycle; otherwise VLD=0 and CA/E1/POL hold.
REQ-020 Back-to-back LD SHALL give one result per cycle, fixed 2-edge latency, no bubbles.
REQ-021 Channel i opaque iff its low TW bits are nonzero.
REQ-022 Select mode: CA = channel SEL; SEL >= NCH SHALL give CA=0.
REQ-023 Priority mode: CA = lowest-index channel that is opaque and has CEN=1; if none, CA = channel NCH-1 data.
REQ-024 POL SHALL be 1 iff low TW bits of the new CA are zero.
REQ-025 E1 SHALL be NOT(registered P1L AND NOT POL-of-new-CA).
REQ-026 Mode, SEL, CEN changes SHALL affect only pixels captured on or after the change edge.

Reset
REQ-027 nRST low SHALL immediately force all stage registers and CA to 0, VLD=0, POL=1, E1=1, TCNT=0.
REQ-028 Data in flight at reset assertion SHALL be discarded; first VLD after release SHALL be 2 edges after first LD.

Configuration
REQ-029 Macro NANAO_PIXMIX_TCNT_EN defined: TCNT SHALL increment on each VLD cycle with POL=1, saturate at 16'hFFFF, and clear to 0 on an edge with FRM=1; FRM wins over a simultaneous increment.
REQ-030 Macro undefined: TCNT SHALL be constant 0, FRM ignored, no counter flops.

Verification
REQ-031 PW=8,NCH=4: LD=1, D={8'h20,8'h11,8'h30,8'h05}, MODE=0, SEL=2 -> 2 edges later CA=8'h11, POL=0, VLD=1 for one cycle.
REQ-032 MODE=1, CEN=4'hF, ch0=8'hA0, ch1=8'h13 -> CA=8'h13, POL=0; with P1L=1 E1=0.
REQ-033 MODE=1, all channels low nibble 0, ch3=8'h70 -> CA=8'h70, POL=1, E1=1.
REQ-034 LD held 1 for 4 cycles, SEL changing 0,1,2,3 -> CA streams ch0..ch3 on 4 consecutive cycles, VLD high all 4.
REQ-035 nRST pulsed low between LD and result edge -> no VLD, CA=0, POL=1, E1=1, TCNT=0.
REQ-036 TCNT_EN: 3 transparent outputs then FRM coincident with 4th -> TCNT reads 3, then 0.

Source files
------------

// File: rtl/nanao_pixmix.sv
// Two-stage pixel mixer: channel select or priority mix with transparency flags.
// Optional transparent-pixel counter enabled by defining NANAO_PIXMIX_TCNT_EN.
module nanao_pixmix #(
   parameter int unsigned PW  = 8,
   parameter int unsigned NCH = 4,
   parameter int unsigned TW  = 4
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              LD,
   input  logic [NCH*PW-1:0] D,
   input  logic [NCH-1:0]    CEN,
   input  logic [2:0]        SEL,
   input  logic              MODE,
   input  logic              P1L,
   input  logic              FRM,
   output logic [PW-1:0]     CA,
   output logic              VLD,
   output logic              E1,
   output logic              POL,
   output logic [15:0]       TCNT
);

   // Stage 1: captured channel data and controls
   logic [NCH*PW-1:0] d_q;
   logic [NCH-1:0]    cen_q;
   logic [2:0]        sel_q;
   logic              mode_q;
   logic              p1l_q;
   logic              pend_q;

   // Stage 2: registered outputs
   logic [PW-1:0] ca_q;
   logic          vld_q;
   logic          e1_q;
   logic          pol_q;

   logic [PW-1:0] mix_pix;
   logic          mix_transp;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         d_q    <= '0;
         cen_q  <= '0;
         sel_q  <= '0;
         mode_q <= 1'b0;
         p1l_q  <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         pend_q <= LD;
         if (LD) begin
            d_q    <= D;
            cen_q  <= CEN;
            sel_q  <= SEL;
            mode_q <= MODE;
            p1l_q  <= P1L;
         end
      end
   end

   always_comb begin
      mix_pix = '0;
      if (mode_q) begin
         mix_pix = d_q[(NCH-1)*PW +: PW];
         // Descending scan so the lowest-index opaque enabled channel wins
         for (int i = NCH - 1; i >= 0; i--) begin
            if (cen_q[i] && (d_q[i*PW +: TW] != '0)) begin
               mix_pix = d_q[i*PW +: PW];
            end
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (int'(sel_q) == i) begin
               mix_pix = d_q[i*PW +: PW];
            end
         end
      end
   end

   assign mix_transp = (mix_pix[TW-1:0] == '0);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ca_q  <= '0;
         vld_q <= 1'b0;
         e1_q  <= 1'b1;
         pol_q <= 1'b1;
      end else begin
         vld_q <= pend_q;
         if (pend_q) begin
            ca_q  <= mix_pix;
            pol_q <= mix_transp;
            e1_q  <= !(p1l_q && !mix_transp);
         end
      end
   end

   assign CA  = ca_q;
   assign VLD = vld_q;
   assign E1  = e1_q;
   assign POL = pol_q;

`ifdef NANAO_PIXMIX_TCNT_EN
   logic [15:0] tcnt_q, tcnt_d;

   always_comb begin
      tcnt_d = tcnt_q;
      if (FRM) begin
         tcnt_d = '0;
      end else if (vld_q && pol_q && (tcnt_q != 16'hFFFF)) begin
         tcnt_d = tcnt_q + 16'd1;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         tcnt_q <= '0;
      end else begin
         tcnt_q <= tcnt_d;
      end
   end

   assign TCNT = tcnt_q;
`else
   logic unused_frm;
   assign unused_frm = FRM;
   assign TCNT       = '0;
`endif

endmodule

// File: tb/tb_nanao_pixmix.sv
// Self-checking bench for nanao_pixmix: directed cases plus randomized traffic
// against a queue-based reference model.
module tb_nanao_pixmix;
   localparam int unsigned PW  = 8;
   localparam int unsigned NCH = 4;
   localparam int unsigned TW  = 4;

   logic              CLK = 1'b0;
   logic              nRST;
   logic              LD;
   logic [NCH*PW-1:0] D;
   logic [NCH-1:0]    CEN;
   logic [2:0]        SEL;
   logic              MODE;
   logic              P1L;
   logic              FRM;
   logic [PW-1:0]     CA;
   logic              VLD;
   logic              E1;
   logic              POL;
   logic [15:0]       TCNT;

   int n_cmp = 0;
   int n_bad = 0;

   nanao_pixmix #(.PW(PW), .NCH(NCH), .TW(TW)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .LD   (LD),
      .D    (D),
      .CEN  (CEN),
      .SEL  (SEL),
      .MODE (MODE),
      .P1L  (P1L),
      .FRM  (FRM),
      .CA   (CA),
      .VLD  (VLD),
      .E1   (E1),
      .POL  (POL),
      .TCNT (TCNT)
   );

   always #5 CLK = ~CLK;

   // Reference model state
   typedef struct {
      logic [PW-1:0] ca;
      logic          p1l;
   } res_t;

   res_t          pipe_q[$];
   logic [PW-1:0] m_ca;
   logic          m_vld, m_pol, m_e1;
   logic [15:0]   m_tcnt;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
      end
   endtask

   function automatic logic [PW-1:0] ref_mix(input logic [NCH*PW-1:0] d, input logic [NCH-1:0] cen,
                                             input logic [2:0] sel, input logic mode);
      longint unsigned ch [NCH];
      for (int i = 0; i < NCH; i++) ch[i] = (longint'(d) >> (i * PW)) % (64'd1 << PW);
      if (!mode) return (int'(sel) < NCH) ? PW'(ch[sel]) : '0;
      for (int i = 0; i < NCH; i++)
         if (cen[i] && (ch[i] % (64'd1 << TW)) != 0) return PW'(ch[i]);
      return PW'(ch[NCH-1]);
   endfunction

   task automatic model_reset();
      pipe_q.delete();
      m_ca = '0; m_vld = 1'b0; m_pol = 1'b1; m_e1 = 1'b1; m_tcnt = '0;
   endtask

   task automatic model_edge();
      res_t r;
`ifdef NANAO_PIXMIX_TCNT_EN
      if (FRM) m_tcnt = '0;
      else if (m_vld && m_pol && m_tcnt != 16'hFFFF) m_tcnt = m_tcnt + 16'd1;
`endif
      m_vld = 1'b0;
      if (pipe_q.size() > 0) begin
         r     = pipe_q.pop_front();
         m_vld = 1'b1;
         m_ca  = r.ca;
         m_pol = (r.ca % (1 << TW)) == 0;
         m_e1  = !(r.p1l && !m_pol);
      end
      if (LD) begin
         r.ca  = ref_mix(D, CEN, SEL, MODE);
         r.p1l = P1L;
         pipe_q.push_back(r);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_vld"}, 32'(VLD), 32'(m_vld));
      chk({tag, "_ca"}, 32'(CA), 32'(m_ca));
      chk({tag, "_pol"}, 32'(POL), 32'(m_pol));
      chk({tag, "_e1"}, 32'(E1), 32'(m_e1));
      chk({tag, "_tcnt"}, 32'(TCNT), 32'(m_tcnt));
   endtask

   // Inputs are set at the falling edge; the model follows the rising edge.
   task automatic cycle(input string tag);
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      check_all(tag);
   endtask

   task automatic set_in(input logic ld, input logic [NCH*PW-1:0] d, input logic [NCH-1:0] cen,
                         input logic [2:0] sel, input logic mode, input logic p1l, input logic frm);
      LD = ld; D = d; CEN = cen; SEL = sel; MODE = mode; P1L = p1l; FRM = frm;
   endtask

   task automatic idle();
      set_in(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pulse_reset(input string tag);
      nRST = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      #1;
      nRST = 1'b1;
   endtask

   initial begin
      logic [NCH*PW-1:0] d;
      nRST = 1'b0;
      idle();
      model_reset();
      #12;
      check_all("reset");
      @(negedge CLK);
      nRST = 1'b1;

      // Select mode, SEL=2
      set_in(1'b1, {8'h20, 8'h11, 8'h30, 8'h05}, 4'h0, 3'd2, 1'b0, 1'b0, 1'b0);
      cycle("sel_cap");
      chk("sel_lat_vld", 32'(VLD), 32'd0);
      idle();
      cycle("sel_out");
      chk("sel_ca", 32'(CA), 32'h11);
      chk("sel_pol", 32'(POL), 32'd0);
      chk("sel_vld", 32'(VLD), 32'd1);
      cycle("sel_drop");
      chk("sel_vld_once", 32'(VLD), 32'd0);

      // Select beyond channel count
      set_in(1'b1, {8'h20, 8'h11, 8'h30, 8'h05}, 4'h0, 3'd5, 1'b0, 1'b0, 1'b0);
      cycle("selhi_cap");
      idle();
      cycle("selhi_out");
      chk("selhi_ca", 32'(CA), 32'h00);

      // Priority: ch0 transparent, ch1 opaque
      set_in(1'b1, {8'h00, 8'h00, 8'h13, 8'hA0}, 4'hF, 3'd0, 1'b1, 1'b1, 1'b0);
      cycle("pri_cap");
      idle();
      cycle("pri_out");
      chk("pri_ca", 32'(CA), 32'h13);
      chk("pri_e1", 32'(E1), 32'd0);

      // Priority: none opaque -> last channel
      set_in(1'b1, {8'h70, 8'h40, 8'h20, 8'h10}, 4'hF, 3'd0, 1'b1, 1'b1, 1'b0);
      cycle("pri0_cap");
      idle();
      cycle("pri0_out");
      chk("pri0_ca", 32'(CA), 32'h70);
      chk("pri0_pol", 32'(POL), 32'd1);
      chk("pri0_e1", 32'(E1), 32'd1);

      // Back-to-back stream, SEL 0..3
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, {8'h20, 8'h11, 8'h30, 8'h05}, 4'h0, 3'(i), 1'b0, 1'b0, 1'b0);
         cycle("stream");
      end
      idle();
      cycle("stream_tail");

      // Reset between capture and result
      set_in(1'b1, {8'h20, 8'h11, 8'h30, 8'h05}, 4'h0, 3'd1, 1'b0, 1'b1, 1'b0);
      cycle("rst_cap");
      idle();
      pulse_reset("rst_mid");
      cycle("rst_after");
      chk("rst_novld", 32'(VLD), 32'd0);

      // Transparent counter: three, then clear alongside the fourth
      set_in(1'b0, '0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1);
      cycle("tc_clr");
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, {8'h20, 8'h10, 8'h30, 8'h40}, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);
         cycle("tc_ld");
      end
      idle();
      cycle("tc_v4");
`ifdef NANAO_PIXMIX_TCNT_EN
      chk("tc_three", 32'(TCNT), 32'd3);
`endif
      FRM = 1'b1;
      cycle("tc_frm");
      chk("tc_zero", 32'(TCNT), 32'd0);
      idle();

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         for (int c = 0; c < NCH; c++) begin
            d[c*PW +: PW] = PW'($urandom);
            if ($urandom_range(1, 0) == 1) d[c*PW +: TW] = '0;
         end
         set_in($urandom_range(3, 0) != 0, d, NCH'($urandom), 3'($urandom), 1'($urandom),
                1'($urandom), $urandom_range(15, 0) == 0);
         if ($urandom_range(63, 0) == 0) pulse_reset("rnd_rst");
         cycle("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
